// File: rtl/ocext_axil_pkg.sv
// ocext_axil_pkg: AXI-Lite response codes, register-file FSM states and byte-lane merge
package ocext_axil_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_RESP} rd_state_t;
   function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] strb);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = strb[k] ? data[8*k +: 8] : old[8*k +: 8];
      return r;
   endfunction
endpackage

// File: rtl/ocext_axil_regfile.sv
// ocext_axil_regfile: AXI-Lite slave exposing NUM_REGS 32-bit registers with per-register write strobes
module ocext_axil_regfile
   import ocext_axil_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int NUM_REGS = 16,
   parameter logic [NUM_REGS*32-1:0] RESET_VALUE = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
   input  logic [2:0]               s_axil_awprot,
   input  logic                     s_axil_awvalid,
   output logic                     s_axil_awready,
   input  logic [DATA_WIDTH-1:0]    s_axil_wdata,
   input  logic [STRB_WIDTH-1:0]    s_axil_wstrb,
   input  logic                     s_axil_wvalid,
   output logic                     s_axil_wready,
   output logic [1:0]               s_axil_bresp,
   output logic                     s_axil_bvalid,
   input  logic                     s_axil_bready,
   input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
   input  logic [2:0]               s_axil_arprot,
   input  logic                     s_axil_arvalid,
   output logic                     s_axil_arready,
   output logic [DATA_WIDTH-1:0]    s_axil_rdata,
   output logic [1:0]               s_axil_rresp,
   output logic                     s_axil_rvalid,
   input  logic                     s_axil_rready,
   output logic [NUM_REGS*32-1:0]   reg_out,
   output logic [NUM_REGS-1:0]      wr_pulse
);
   localparam int IW = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS*4);

   wr_state_t ws;
   rd_state_t rs;
   logic [ADDR_WIDTH-1:0] aw_q, c_addr;
   logic [DATA_WIDTH-1:0] wd_q, c_data;
   logic [STRB_WIDTH-1:0] wstrb_q, c_strb;
   logic [NUM_REGS*32-1:0] regs;
   logic aw_hs, w_hs, commit, c_in, r_in;
   logic [IW-1:0] c_idx, r_idx;
   logic unused_prot;

   assign unused_prot = ^{s_axil_awprot, s_axil_arprot};
   assign s_axil_awready = ws == W_IDLE || ws == W_HAVE_W;
   assign s_axil_wready = ws == W_IDLE || ws == W_HAVE_AW;
   assign s_axil_bvalid = ws == W_RESP;
   assign s_axil_arready = rs == R_IDLE;
   assign s_axil_rvalid = rs == R_RESP;
   assign reg_out = regs;
   assign aw_hs = s_axil_awvalid && s_axil_awready;
   assign w_hs = s_axil_wvalid && s_axil_wready;
   assign commit = (ws == W_IDLE && aw_hs && w_hs) || (ws == W_HAVE_AW && w_hs) || (ws == W_HAVE_W && aw_hs);
   // Whichever half arrived earlier comes from its latch, the other straight from the bus
   assign c_addr = ws == W_HAVE_AW ? aw_q : s_axil_awaddr;
   assign c_data = ws == W_HAVE_W ? wd_q : s_axil_wdata;
   assign c_strb = ws == W_HAVE_W ? wstrb_q : s_axil_wstrb;
   assign c_in = c_addr < LIMIT;
   assign c_idx = c_addr[IW+1:2];
   assign r_in = s_axil_araddr < LIMIT;
   assign r_idx = s_axil_araddr[IW+1:2];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ws <= W_IDLE;
         aw_q <= '0;
         wd_q <= '0;
         wstrb_q <= '0;
         regs <= RESET_VALUE;
         wr_pulse <= '0;
         s_axil_bresp <= RESP_OKAY;
      end else begin
         wr_pulse <= '0;
         if (commit) begin
            ws <= W_RESP;
            s_axil_bresp <= c_in ? RESP_OKAY : RESP_SLVERR;
            if (c_in) begin
               regs[{c_idx, 5'd0} +: 32] <= strb_merge(regs[{c_idx, 5'd0} +: 32], c_data, c_strb);
               wr_pulse <= NUM_REGS'(1) << c_idx;
            end
         end else if (ws == W_IDLE && aw_hs) begin
            ws <= W_HAVE_AW;
            aw_q <= s_axil_awaddr;
         end else if (ws == W_IDLE && w_hs) begin
            ws <= W_HAVE_W;
            wd_q <= s_axil_wdata;
            wstrb_q <= s_axil_wstrb;
         end else if (ws == W_RESP && s_axil_bready) begin
            ws <= W_IDLE;
         end
      end
   end

   // Reads sample regs before any same-edge commit lands, so they return the old value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rs <= R_IDLE;
         s_axil_rdata <= '0;
         s_axil_rresp <= RESP_OKAY;
      end else if (rs == R_IDLE && s_axil_arvalid) begin
         rs <= R_RESP;
         s_axil_rdata <= r_in ? regs[{r_idx, 5'd0} +: 32] : '0;
         s_axil_rresp <= r_in ? RESP_OKAY : RESP_SLVERR;
      end else if (rs == R_RESP && s_axil_rready) begin
         rs <= R_IDLE;
      end
   end
endmodule

// File: tb/tb_ocext_axil_regfile.sv
// tb_ocext_axil_regfile: scoreboard bench; drivers push expected responses, a negedge monitor checks them
module tb_ocext_axil_regfile;
   import ocext_axil_pkg::*;
   localparam int N = 16;

   logic clk = 0, rst_n = 0;
   logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
   logic [2:0] awprot = 0, arprot = 0;
   logic [3:0] wstrb = 0;
   logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
   logic arvalid = 0, arready, rvalid, rready = 1;
   logic [1:0] bresp, rresp;
   logic [N*32-1:0] reg_out;
   logic [N-1:0] wr_pulse;

   ocext_axil_regfile #(.NUM_REGS(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
      .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
      .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
      .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
      .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
      .reg_out(reg_out), .wr_pulse(wr_pulse)
   );

   always #5 clk = ~clk;

   typedef struct { logic [1:0] resp; logic [N-1:0] pulse; } bexp_t;
   typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
   bexp_t bq[$];
   rexp_t rq[$];
   bexp_t be;
   rexp_t re;
   logic [31:0] mdl [N];
   int checks = 0, fails = 0;
   bit rand_rdy = 0;

   function automatic logic [N*32-1:0] mdl_img();
      logic [N*32-1:0] img;
      for (int i = 0; i < N; i++) img[32*i +: 32] = mdl[i];
      return img;
   endfunction

   task automatic chk(input string name, input logic [N*32-1:0] act, input logic [N*32-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit sig(input int w);
      case (w)
         0: return awready;
         1: return wready;
         2: return awready && wready;
         3: return arready;
         4: return bvalid && bready;
         default: return rvalid && rready;
      endcase
   endfunction

   task automatic wait_sig(input int w, input string name);
      int n = 0;
      while (!sig(w) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!sig(w)) begin
         checks++;
         fails++;
         $display("FAIL timeout_%s: still low after %0d cycles, required high", name, n);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bexp_t e;
      if (a < N*4) begin
         int i = int'(a[5:2]);
         for (int k = 0; k < 4; k++) if (s[k]) mdl[i][8*k +: 8] = d[8*k +: 8];
         e.resp = RESP_OKAY;
         e.pulse = N'(1) << i;
      end else begin
         e.resp = RESP_SLVERR;
         e.pulse = '0;
      end
      bq.push_back(e);
   endtask

   task automatic push_read(input logic [31:0] a);
      rexp_t e;
      e.data = (a < N*4) ? mdl[a[5:2]] : 32'h0;
      e.resp = (a < N*4) ? RESP_OKAY : RESP_SLVERR;
      rq.push_back(e);
   endtask

   task automatic drive_aw(input logic [31:0] a);
      awaddr = a;
      awvalid = 1;
      @(negedge clk);
      wait_sig(0, "awready");
      @(posedge clk);
      #1 awvalid = 0;
   endtask

   task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
      wdata = d;
      wstrb = s;
      wvalid = 1;
      @(negedge clk);
      wait_sig(1, "wready");
      @(posedge clk);
      #1 wvalid = 0;
   endtask

   task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int mode, input int gap);
      if (mode == 0) begin
         awaddr = a;
         wdata = d;
         wstrb = s;
         awvalid = 1;
         wvalid = 1;
         @(negedge clk);
         wait_sig(2, "aw_w_ready");
         @(posedge clk);
         #1;
         awvalid = 0;
         wvalid = 0;
      end else if (mode == 1) begin
         drive_aw(a);
         idle(gap);
         drive_w(d, s);
      end else begin
         drive_w(d, s);
         idle(gap);
         drive_aw(a);
      end
      @(negedge clk);
      chk("bvalid_latency", bvalid, 1);
      wait_sig(4, "b_handshake");
      @(posedge clk);
      #1;
   endtask

   task automatic drive_read(input logic [31:0] a);
      araddr = a;
      arvalid = 1;
      @(negedge clk);
      wait_sig(3, "arready");
      @(posedge clk);
      #1 arvalid = 0;
      @(negedge clk);
      chk("rvalid_latency", rvalid, 1);
      wait_sig(5, "r_handshake");
      @(posedge clk);
      #1;
   endtask

   task automatic write_tx(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int mode, input int gap);
      push_write(a, d, s);
      drive_write(a, d, s, mode, gap);
   endtask

   task automatic read_tx(input logic [31:0] a);
      push_read(a);
      drive_read(a);
   endtask

   always @(posedge clk) if (rand_rdy) begin
      #1;
      bready = 1'($urandom_range(0, 1));
      rready = 1'($urandom_range(0, 1));
   end

   logic bv_d = 0, rv_d = 0, rr_d = 0;
   logic [1:0] bs_d = 0, rs_d = 0;
   logic [31:0] rd_d = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         bv_d = 0;
         rv_d = 0;
         rr_d = 0;
      end else begin
         if (bvalid && !bv_d) begin
            if (bq.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_bvalid: got bvalid=1 with no write outstanding at %0t", $time);
            end else begin
               be = bq.pop_front();
               chk("bresp", bresp, be.resp);
               chk("wr_pulse", wr_pulse, be.pulse);
               chk("reg_out", reg_out, mdl_img());
            end
         end else chk("wr_pulse_idle", wr_pulse, 0);
         if (bvalid && bv_d) chk("bresp_stable", bresp, bs_d);
         if (rvalid && rv_d && !rr_d) begin
            chk("rdata_stable", rdata, rd_d);
            chk("rresp_stable", rresp, rs_d);
         end
         if (rvalid && rready) begin
            if (rq.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_rvalid: got rdata=%0h with no read outstanding", rdata);
            end else begin
               re = rq.pop_front();
               chk("rdata", rdata, re.data);
               chk("rresp", rresp, re.resp);
            end
         end
         bv_d = bvalid;
         bs_d = bresp;
         rv_d = rvalid;
         rr_d = rready;
         rd_d = rdata;
         rs_d = rresp;
      end
   end

   task automatic check_reset_state();
      chk("rst_awready", awready, 1);
      chk("rst_wready", wready, 1);
      chk("rst_arready", arready, 1);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_reg_out", reg_out, mdl_img());
      chk("rst_wr_pulse", wr_pulse, 0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) mdl[i] = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      check_reset_state();
      chk("rst_bresp", bresp, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_rdata", rdata, 0);
      @(posedge clk);
      #1;

      write_tx(32'h8, 32'hDEADBEEF, 4'hF, 0, 0);
      chk("reg2_deadbeef", reg_out[95:64], 32'hDEADBEEF);
      write_tx(32'h4, 32'h11223344, 4'b0101, 2, 3);
      chk("reg1_merge", reg_out[63:32], 32'h00220044);
      write_tx(32'h40, 32'hCAFEF00D, 4'hF, 1, 1);
      read_tx(32'h40);
      write_tx(32'h14, 32'h55AA55AA, 4'b0000, 0, 0);

      rready = 0;
      push_read(32'h8);
      fork
         drive_read(32'h8);
         begin
            @(posedge clk);
            repeat (5) begin
               @(negedge clk);
               chk("stall_arready", arready, 0);
               chk("stall_rvalid", rvalid, 1);
            end
            @(posedge clk);
            #1 rready = 1;
         end
      join

      write_tx(32'hC, 32'h1, 4'hF, 0, 0);
      push_read(32'hC);
      push_write(32'hC, 32'h2, 4'hF);
      fork
         drive_write(32'hC, 32'h2, 4'hF, 0, 0);
         drive_read(32'hC);
      join
      chk("reg3_new", reg_out[127:96], 32'h2);

      drive_aw(32'h10);
      rst_n = 0;
      @(posedge clk);
      #1 rst_n = 1;
      for (int i = 0; i < N; i++) mdl[i] = 0;
      @(negedge clk);
      check_reset_state();
      repeat (4) begin
         @(negedge clk);
         chk("no_bvalid_after_rst", bvalid, 0);
      end
      @(posedge clk);
      #1;

      rand_rdy = 1;
      for (int t = 0; t < 250; t++) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            write_tx(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3));
         else
            read_tx(a);
      end
      rand_rdy = 0;
      @(posedge clk);
      #2;
      bready = 1;
      rready = 1;
      repeat (3) @(negedge clk);
      chk("bq_drained", bq.size(), 0);
      chk("rq_drained", rq.size(), 0);
      chk("final_reg_out", reg_out, mdl_img());
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
